aes_enc_ctrl: RTL and testbench

- Sequencing controller for the iterative AES-128 encryption round datapath.
- Accepts a start handshake and drives the four round-select controls (full_enc, zero_rnd, final_rnd, key_sel) cycle by cycle.
- Publishes the current round index to the key schedule and pulses done when the ciphertext register holds the result.
- Accounts for the S-box latency between the datapath state register output and the mapped input.

---
 rtl/aes_enc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_aes_enc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_ctrl.sv
// Round sequencer for an iterative AES encryption datapath.
// All outputs are registered and decoded from the next state and round counter.
module aes_enc_ctrl #(
    parameter int unsigned NR       = 10,
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic [3:0] rnd_idx_o,
    output logic       full_enc_ctrl_o,
    output logic       final_rnd_ctrl_o,
    output logic       key_sel_ctrl_o,
    output logic       zero_rnd_ctrl_o,
    output logic       done_o
);

    typedef enum logic [2:0] {StIdle, StLoad, StWait, StRound, StDone} state_e;

    localparam logic [3:0] NrLast  = 4'(NR);
    localparam logic [1:0] LatLast = 2'(SBOX_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] wait_q, wait_d;

    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic [3:0] idx_q, idx_d;
    logic       full_q, full_d;
    logic       final_q, final_d;
    logic       ksel_q, ksel_d;
    logic       zrnd_q, zrnd_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    round_d = 4'd0;
                    wait_d  = 2'd0;
                end
            end
            StLoad: begin
                round_d = 4'd1;
                wait_d  = 2'd0;
                state_d = (SBOX_LAT > 0) ? StWait : StRound;
            end
            StWait: begin
                if (wait_q == LatLast) begin
                    wait_d  = 2'd0;
                    state_d = StRound;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StRound: begin
                if (round_q >= NrLast) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = (SBOX_LAT > 0) ? StWait : StRound;
                end
            end
            StDone: begin
                round_d = 4'd0;
                state_d = start_i ? StLoad : StIdle;
            end
            default: begin
                state_d = StIdle;
                round_d = 4'd0;
                wait_d  = 2'd0;
            end
        endcase
        // Abort overrides every transition once an operation has begun.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            round_d = 4'd0;
            wait_d  = 2'd0;
        end
    end

    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        idx_d   = 4'd0;
        full_d  = 1'b0;
        final_d = 1'b0;
        ksel_d  = 1'b0;
        zrnd_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            StIdle: ready_d = 1'b1;
            StLoad: begin
                busy_d  = 1'b1;
                full_d  = 1'b1;
                final_d = 1'b1;
                ksel_d  = 1'b1;
                zrnd_d  = 1'b1;
            end
            StWait: begin
                busy_d = 1'b1;
                idx_d  = round_d;
            end
            StRound: begin
                busy_d  = 1'b1;
                idx_d   = round_d;
                zrnd_d  = 1'b1;
                final_d = (round_d == NrLast);
            end
            StDone: begin
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            wait_q  <= 2'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= 4'd0;
            full_q  <= 1'b0;
            final_q <= 1'b0;
            ksel_q  <= 1'b0;
            zrnd_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wait_q  <= wait_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            final_q <= final_d;
            ksel_q  <= ksel_d;
            zrnd_q  <= zrnd_d;
            done_q  <= done_d;
        end
    end

    assign ready_o          = ready_q;
    assign busy_o           = busy_q;
    assign rnd_idx_o        = idx_q;
    assign full_enc_ctrl_o  = full_q;
    assign final_rnd_ctrl_o = final_q;
    assign key_sel_ctrl_o   = ksel_q;
    assign zero_rnd_ctrl_o  = zrnd_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Bench for aes_enc_ctrl: three instances (S-box latency 0/1/3) each steering a behavioural
// AES round datapath; instance 1 is checked cycle by cycle against a latency-formula model.
module tb_aes_enc_ctrl;

    localparam int NR = 10;
    localparam int P  = 2;           // SBOX_LAT + 1 for the main instance
    localparam int KD = NR * P + 1;  // offset of the done cycle from LOAD
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]        start_v = '0, abort_v = '0;
    logic [2:0]        ready_v, busy_v, done_v, fe_v, fr_v, ks_v, zr_v;
    logic [2:0][3:0]   idx_v;
    logic [2:0][127:0] dp_v;
    logic [127:0]      pt, key;
    logic [7:0]        sbox_t [256];

    int n_checks = 0;
    int n_fails  = 0;
    int mk       = -1;
    logic [127:0] exp_q [$];

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_calc(logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[103-32*c -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_key(logic [127:0] k, int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        if (idx > 10) return '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'd2);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] aes_ref(logic [127:0] p, logic [127:0] k);
        logic [127:0] s = p ^ round_key(k, 0);
        for (int r = 1; r <= NR; r++) begin
            s = sub_shift(s);
            if (r < NR) s = mix_cols(s);
            s ^= round_key(k, r);
        end
        return s;
    endfunction

    // Expected {ready, busy, done, full_enc, final_rnd, key_sel, zero_rnd} at offset k from LOAD.
    function automatic logic [6:0] exp_ctl(int k);
        if (k < 0) return 7'b1000000;
        if (k == 0) return 7'b0101111;
        if (k == KD) return 7'b1010000;
        if (k % P == 0) return {4'b0100, (k / P) == NR, 2'b01};
        return 7'b0100000;
    endfunction

    function automatic logic [3:0] exp_idx(int k);
        return (k == 0) ? 4'd0 : 4'((k + P - 1) / P);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        logic [127:0] dp_q = '0, d1 = '0, d2 = '0, d3 = '0;

        aes_enc_ctrl #(.NR(NR), .SBOX_LAT(LAT)) u_dut (
            .clk             (clk),
            .nrst            (nrst),
            .start_i         (start_v[g]),
            .abort_i         (abort_v[g]),
            .ready_o         (ready_v[g]),
            .busy_o          (busy_v[g]),
            .rnd_idx_o       (idx_v[g]),
            .full_enc_ctrl_o (fe_v[g]),
            .final_rnd_ctrl_o(fr_v[g]),
            .key_sel_ctrl_o  (ks_v[g]),
            .zero_rnd_ctrl_o (zr_v[g]),
            .done_o          (done_v[g])
        );

        // Datapath register evaluated mid-cycle; dN holds the register N cycles back,
        // which is what the S-box pipeline presents to the round logic.
        always @(negedge clk) begin : dp_model
            logic [127:0] src, kused, nxt;
            src   = (LAT == 0) ? dp_q : (LAT == 1) ? d1 : (LAT == 2) ? d2 : d3;
            kused = zr_v[g] ? (ks_v[g] ? key : round_key(key, int'(idx_v[g]))) : '0;
            nxt   = fe_v[g] ? (pt ^ kused)
                  : ((fr_v[g] ? sub_shift(src) : mix_cols(sub_shift(src))) ^ kused);
            d3   <= d2;
            d2   <= d1;
            d1   <= dp_q;
            dp_q <= nxt;
        end
        assign dp_v[g] = dp_q;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ctl1();
        return {ready_v[1], busy_v[1], done_v[1], fe_v[1], fr_v[1], ks_v[1], zr_v[1]};
    endfunction

    // One clock of the main instance: drive, advance, update model, compare.
    task automatic step(input bit st, input bit ab);
        start_v[1] = st;
        abort_v[1] = ab;
        @(posedge clk);
        #1;
        if (ab && mk >= 0) begin
            mk = -1;
            exp_q.delete();
        end else if (mk < 0 || mk == KD) begin
            if (st) begin
                mk = 0;
                exp_q.push_back(aes_ref(pt, key));
            end else begin
                mk = -1;
            end
        end else begin
            mk++;
        end
        chk("ctl", 128'(ctl1()), 128'(exp_ctl(mk)));
        if (mk >= 0 && mk < KD) chk("rnd_idx", 128'(idx_v[1]), 128'(exp_idx(mk)));
        if (mk == KD && exp_q.size() > 0) chk("cipher", dp_v[1], exp_q.pop_front());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc, d0, d2, p0, p2;
        logic [127:0] c0, c2, cf;
        int dones [$];

        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        pt  = FIPS_PT;
        key = FIPS_KEY;

        #1 nrst = 1'b0;
        #20;
        for (int g = 0; g < 3; g++) begin
            chk("reset_ctl", 128'({ready_v[g], busy_v[g], done_v[g], fe_v[g], fr_v[g], ks_v[g],
                                   zr_v[g]}), 128'(7'b1000000));
            chk("reset_idx", 128'(idx_v[g]), 128'd0);
        end
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 vector on the main instance.
        dc = 0;
        cf = '0;
        for (int n = 1; n <= 30; n++) begin
            step(n == 1, 1'b0);
            if (done_v[1] && dc == 0) begin
                dc = n;
                cf = dp_v[1];
            end
        end
        chk("fips_latency", 128'(dc), 128'd22);
        chk("fips_cipher", cf, FIPS_CT);

        // Latency 0 and 3 instances in parallel.
        start_v[0] = 1'b1;
        start_v[2] = 1'b1;
        d0 = 0; d2 = 0; p0 = 0; p2 = 0; c0 = '0; c2 = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start_v = '0;
            if (done_v[0]) begin p0++; if (d0 == 0) begin d0 = c; c0 = dp_v[0]; end end
            if (done_v[2]) begin p2++; if (d2 == 0) begin d2 = c; c2 = dp_v[2]; end end
        end
        chk("lat0_done", 128'(d0), 128'd12);
        chk("lat3_done", 128'(d2), 128'd42);
        chk("lat0_cipher", c0, FIPS_CT);
        chk("lat3_cipher", c2, FIPS_CT);
        chk("lat0_pulses", 128'(p0), 128'd1);
        chk("lat3_pulses", 128'(p2), 128'd1);

        // start held high: back-to-back operations, mid-run starts ignored.
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 1; n <= 50; n++) begin
            step(1'b1, 1'b0);
            if (done_v[1]) dones.push_back(n);
        end
        chk("b2b_count", 128'(dones.size()), 128'd2);
        if (dones.size() == 2) chk("b2b_gap", 128'(dones[1] - dones[0]), 128'd22);
        step(1'b0, 1'b1);

        // Abort in round 4, then a clean run.
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 1'b0);
        for (int n = 0; n < 20 && mk != 4 * P; n++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("abort_ready", 128'(ready_v[1]), 128'd1);
        chk("abort_done", 128'(done_v[1]), 128'd0);
        for (int n = 1; n <= 24; n++) step(n == 1, 1'b0);

        // Asynchronous reset in round 5, then a full run.
        step(1'b1, 1'b0);
        for (int n = 0; n < 20 && mk != 5 * P; n++) step(1'b0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("arst_ctl", 128'(ctl1()), 128'(7'b1000000));
        chk("arst_idx", 128'(idx_v[1]), 128'd0);
        mk = -1;
        exp_q.delete();
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1;
        dc = 0;
        for (int n = 1; n <= 24; n++) begin
            step(n == 1, 1'b0);
            if (done_v[1] && dc == 0) dc = n;
        end
        chk("post_reset_latency", 128'(dc), 128'd22);

        // Randomized start/abort traffic.
        for (int n = 0; n < 1500; n++) begin
            bit st, ab;
            if (mk < 0 || mk == KD) begin
                pt  = {$urandom, $urandom, $urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
            end
            st = ($urandom_range(0, 3) == 0);
            ab = (mk >= 0) && ($urandom_range(0, 30) == 0);
            step(st, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
